// File: rtl/prog_fetch.sv
// prog_fetch: program counter, instruction register and 2-level call stack
// for a 12-bit instruction fetch unit.
//
// Ports:
//   clk2       in   system clock; all state updates on its rising edge
//   reset      in   asynchronous active-high reset
//   ce         in   clock enable; when low, all state holds
//   rom_data   in   program word at rom_addr (combinational, same cycle)
//   skip       in   annul request from the decoder (flushes next inst)
//   pcl_we     in   PCL write strobe; pc <= {pa,0,aluout}
//   aluout     in   ALU result for PCL writes
//   pa         in   page-select bits
//   rom_addr   out  fetch address (== pc)
//   pc         out  current program counter
//   inst       out  registered instruction word
//   stk_depth  out  stack occupancy 0..2
//   stk_ovf    out  sticky stack overflow
//   stk_unf    out  sticky stack underflow
module prog_fetch #(
  parameter logic [10:0] RESET_VEC = 11'h7FF
) (
  input  logic        clk2,
  input  logic        reset,
  input  logic        ce,
  input  logic [11:0] rom_data,
  input  logic        skip,
  input  logic        pcl_we,
  input  logic [7:0]  aluout,
  input  logic [1:0]  pa,
  output logic [10:0] rom_addr,
  output logic [10:0] pc,
  output logic [11:0] inst,
  output logic [1:0]  stk_depth,
  output logic        stk_ovf,
  output logic        stk_unf
);

  logic [10:0] r_pc, r_stk1, r_stk2;
  logic [11:0] r_inst;
  logic [1:0]  r_depth;
  logic        r_ovf, r_unf;

  logic        w_goto, w_call, w_retlw, w_push, w_pop, w_flush;
  logic [10:0] w_pc_nxt;

  // Branch decode works on the instruction already latched, so every taken
  // branch costs exactly one flushed fetch.
  assign w_goto  = (r_inst[11:9] == 3'b101);
  assign w_call  = (r_inst[11:8] == 4'b1001);
  assign w_retlw = (r_inst[11:8] == 4'b1000);

  // A PCL write overrides the branch and also suppresses its stack effect.
  assign w_push  = w_call  & ~pcl_we;
  assign w_pop   = w_retlw & ~pcl_we;
  assign w_flush = pcl_we | w_goto | w_call | w_retlw | skip;

  always_comb begin
    w_pc_nxt = r_pc + 11'd1;  // natural wrap 7FF -> 000
    if (pcl_we)       w_pc_nxt = {pa, 1'b0, aluout};
    else if (w_goto)  w_pc_nxt = {pa, r_inst[8:0]};
    else if (w_call)  w_pc_nxt = {pa, 1'b0, r_inst[7:0]};
    else if (w_retlw) w_pc_nxt = r_stk1;
  end

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_VEC;
      r_inst  <= 12'h000;
      r_stk1  <= 11'h000;
      r_stk2  <= 11'h000;
      r_depth <= 2'd0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (ce) begin
      r_pc   <= w_pc_nxt;
      r_inst <= w_flush ? 12'h000 : rom_data;
      if (w_push) begin
        // r_pc already points past the CALL, so it is the return address.
        r_stk2 <= r_stk1;
        r_stk1 <= r_pc;
        if (r_depth == 2'd2) r_ovf   <= 1'b1;
        else                 r_depth <= r_depth + 2'd1;
      end else if (w_pop) begin
        // stk2 is left as-is; an empty pop keeps returning the stale top.
        r_stk1 <= r_stk2;
        if (r_depth == 2'd0) r_unf   <= 1'b1;
        else                 r_depth <= r_depth - 2'd1;
      end
    end
  end

  assign rom_addr  = r_pc;
  assign pc        = r_pc;
  assign inst      = r_inst;
  assign stk_depth = r_depth;
  assign stk_ovf   = r_ovf;
  assign stk_unf   = r_unf;

endmodule

// File: tb/tb_prog_fetch.sv
module tb_prog_fetch;

  logic        clk2, reset, ce, skip, pcl_we;
  logic [11:0] rom_data;
  logic [7:0]  aluout;
  logic [1:0]  pa;
  logic [10:0] rom_addr, pc;
  logic [11:0] inst;
  logic [1:0]  stk_depth;
  logic        stk_ovf, stk_unf;

  logic [11:0] rom [0:2047];
  assign rom_data = rom[rom_addr];

  prog_fetch #(.RESET_VEC(11'h7FF)) dut (
    .clk2(clk2), .reset(reset), .ce(ce), .rom_data(rom_data), .skip(skip),
    .pcl_we(pcl_we), .aluout(aluout), .pa(pa), .rom_addr(rom_addr), .pc(pc),
    .inst(inst), .stk_depth(stk_depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Return stack kept as a two-entry list, front = top. Entries that have
  // been popped stay in the list as stale values, matching the rule that an
  // empty pop still returns whatever the top slot holds.
  logic [10:0] m_pc;
  logic [11:0] m_inst;
  logic [10:0] m_stk[$];
  int          m_depth;
  logic        m_ovf, m_unf;

  task automatic model_reset();
    m_pc = 11'h7FF; m_inst = 12'h000; m_stk = {11'h000, 11'h000};
    m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic s, input logic w,
                            input logic [7:0] a, input logic [1:0] p);
    logic [3:0]  op;
    logic [10:0] npc, t;
    bit          is_goto, is_call, is_ret;
    if (!c) return;
    op      = m_inst[11:8];
    is_goto = (op == 4'hA) || (op == 4'hB);
    is_call = (op == 4'h9);
    is_ret  = (op == 4'h8);
    if (w) npc = {p, 1'b0, a};
    else if (is_goto) npc = {p, m_inst[8:0]};
    else if (is_call) begin
      npc = {p, 1'b0, m_inst[7:0]};
      m_stk.push_front(m_pc);
      void'(m_stk.pop_back());
      if (m_depth == 2) m_ovf = 1'b1; else m_depth++;
    end else if (is_ret) begin
      npc = m_stk[0];
      t = m_stk[1];
      m_stk = {t, t};
      if (m_depth == 0) m_unf = 1'b1; else m_depth--;
    end else npc = 11'((int'(m_pc) + 1) % 2048);
    m_inst = (w || is_goto || is_call || is_ret || s) ? 12'h000 : rom[m_pc];
    m_pc = npc;
  endtask

  task automatic cmp_model();
    chk("model_pc", 32'(pc), 32'(m_pc));
    chk("model_addr", 32'(rom_addr), 32'(m_pc));
    chk("model_inst", 32'(inst), 32'(m_inst));
    chk("model_depth", 32'(stk_depth), 32'(m_depth));
    chk("model_ovf", 32'(stk_ovf), 32'(m_ovf));
    chk("model_unf", 32'(stk_unf), 32'(m_unf));
  endtask

  // Drive one cycle of inputs between edges, advance model, check after edge.
  task automatic step(input logic c, input logic s, input logic w,
                      input logic [7:0] a, input logic [1:0] p);
    ce = c; skip = s; pcl_we = w; aluout = a; pa = p;
    model_step(c, s, w, a, p);
    @(posedge clk2); #1;
    cmp_model();
  endtask

  task automatic run1();
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_pc"}, 32'(pc), 32'h7FF);
    chk({nm, "_inst"}, 32'(inst), 32'h000);
    chk({nm, "_depth"}, 32'(stk_depth), 32'h0);
    chk({nm, "_flags"}, 32'({stk_ovf, stk_unf}), 32'h0);
  endtask

  // Reset asserted between edges; its effect must not wait for a clock.
  task automatic async_reset();
    #2; reset = 1'b1; #1;
    model_reset();
    chk_reset_vals("rst_async");
    @(posedge clk2); #1;
    chk_reset_vals("rst_held");
    reset = 1'b0;
  endtask

  task automatic init_rom();
    for (int a = 0; a < 2048; a++) rom[a] = 12'(a);  // top bit 0: never a branch
  endtask

  typedef struct {
    logic        ce, skip, pcl_we;
    logic [7:0]  alu;
    logic [1:0]  pa;
    logic [10:0] exp_pc;
    logic [11:0] exp_inst;
    logic [1:0]  exp_depth;
  } vec_t;

  function automatic vec_t mkv(input logic [10:0] p, input logic [11:0] i, input logic [1:0] d);
    vec_t v;
    v.ce = 1'b1; v.skip = 1'b0; v.pcl_we = 1'b0; v.alu = 8'h00; v.pa = 2'b00;
    v.exp_pc = p; v.exp_inst = i; v.exp_depth = d;
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    logic c, s, w;
    logic [7:0] a;
    logic [1:0] p;

    // GOTO from reset, then CALL 0x20 at 0x005 and RETLW at 0x020.
    tbl[0]  = mkv(11'h000, 12'hA10, 2'd0);
    tbl[1]  = mkv(11'h010, 12'h000, 2'd0);
    tbl[2]  = mkv(11'h011, 12'hA04, 2'd0);
    tbl[3]  = mkv(11'h004, 12'h000, 2'd0);
    tbl[4]  = mkv(11'h005, 12'h004, 2'd0);
    tbl[5]  = mkv(11'h006, 12'h920, 2'd0);
    tbl[6]  = mkv(11'h020, 12'h000, 2'd1);
    tbl[7]  = mkv(11'h021, 12'h8AB, 2'd1);
    tbl[8]  = mkv(11'h006, 12'h000, 2'd0);
    tbl[9]  = mkv(11'h007, 12'h006, 2'd0);
    tbl[10] = mkv(11'h008, 12'h007, 2'd0);

    reset = 1'b1; ce = 1'b0; skip = 1'b0; pcl_we = 1'b0; aluout = 8'h00; pa = 2'b00;
    init_rom();
    rom[11'h7FF] = 12'hA10;  // GOTO 0x010
    rom[11'h010] = 12'hA04;  // GOTO 0x004
    rom[11'h005] = 12'h920;  // CALL 0x020
    rom[11'h020] = 12'h8AB;  // RETLW
    model_reset();
    #12;
    chk_reset_vals("rst_init");
    @(posedge clk2); #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].ce, tbl[i].skip, tbl[i].pcl_we, tbl[i].alu, tbl[i].pa);
      chk($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].exp_pc));
      chk($sformatf("tbl%0d_inst", i), 32'(inst), 32'(tbl[i].exp_inst));
      chk($sformatf("tbl%0d_depth", i), 32'(stk_depth), 32'(tbl[i].exp_depth));
    end

    // PCL write while CALL is on inst: PCL wins, stack untouched.
    init_rom();
    rom[11'h7FF] = 12'hA30; rom[11'h030] = 12'h940;
    rom[11'h040] = 12'h980; rom[11'h23D] = 12'h800;
    async_reset();
    for (int e = 1; e <= 5; e++) run1();
    chk("pclw_pre_depth", 32'(stk_depth), 32'd1);
    chk("pclw_pre_inst", 32'(inst), 32'h980);
    step(1'b1, 1'b0, 1'b1, 8'h3C, 2'b01);
    chk("pclw_pc", 32'(pc), 32'h23C);
    chk("pclw_depth", 32'(stk_depth), 32'd1);
    chk("pclw_inst", 32'(inst), 32'h000);
    run1();
    chk("pclw_tgt_inst", 32'(inst), 32'h23C);
    run1(); run1();
    chk("pclw_ret_pc", 32'(pc), 32'h031);
    chk("pclw_ret_depth", 32'(stk_depth), 32'd0);

    // Skip in straight-line code at 0x100.
    init_rom();
    rom[11'h7FF] = 12'hAFE;
    async_reset();
    for (int e = 1; e <= 4; e++) run1();
    chk("skip_pre_pc", 32'(pc), 32'h100);
    step(1'b1, 1'b1, 1'b0, 8'h00, 2'b00);
    chk("skip_inst", 32'(inst), 32'h000);
    chk("skip_pc", 32'(pc), 32'h101);
    run1();
    chk("skip_after_inst", 32'(inst), 32'h101);
    chk("skip_after_pc", 32'(pc), 32'h102);

    // Three nested CALLs then three RETLWs.
    init_rom();
    rom[11'h7FF] = 12'hA40; rom[11'h040] = 12'h950; rom[11'h050] = 12'h960;
    rom[11'h060] = 12'h970; rom[11'h070] = 12'h800; rom[11'h061] = 12'h800;
    rom[11'h051] = 12'h800;
    async_reset();
    for (int e = 1; e <= 14; e++) begin
      run1();
      case (e)
        6:  chk("nest_ovf_before", 32'(stk_ovf), 32'd0);
        8:  begin chk("nest_ovf", 32'(stk_ovf), 32'd1);
                  chk("nest_depth2", 32'(stk_depth), 32'd2); end
        10: chk("nest_ret3", 32'(pc), 32'h061);
        12: begin chk("nest_ret2", 32'(pc), 32'h051);
                  chk("nest_unf_before", 32'(stk_unf), 32'd0); end
        14: begin chk("nest_ret2b", 32'(pc), 32'h051);
                  chk("nest_unf", 32'(stk_unf), 32'd1);
                  chk("nest_depth0", 32'(stk_depth), 32'd0); end
        default: ;
      endcase
    end

    // ce low for 3 cycles with skip/pcl_we active: everything holds.
    for (int e = 0; e < 3; e++) begin
      step(1'b0, 1'b1, 1'b1, 8'h55, 2'b11);
      chk("hold_pc", 32'(pc), 32'h051);
      chk("hold_flags", 32'({stk_ovf, stk_unf}), 32'h3);
    end
    async_reset();

    // Randomized run against the model.
    for (int a2 = 0; a2 < 2048; a2++) rom[a2] = 12'($urandom_range(0, 4095));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      c = 1'($urandom_range(0, 9) != 0);
      s = 1'($urandom_range(0, 6) == 0);
      w = 1'($urandom_range(0, 9) == 0);
      a = 8'($urandom);
      p = 2'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset();
      else step(c, s, w, a, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
